laplace_scan_ctrl: RTL and testbench

- Frame sequencer for the combinational 5-point Laplacian filter (laplace_aproximado_5).
- Scans a ROWS x COLS 8-bit image held in a synchronous single-port read memory.
- Fetches the five taps (b, d, e, f, h) for every interior pixel, drives them to the filter, and writes the filtered pixel s[7:0] to an output stream/memory with a ready handshake.
- Replaces the behavioural scan loop with synthesizable control.

---
 rtl/laplace_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_laplace_scan_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laplace_scan_ctrl.sv
// Frame sequencer for the 5-point Laplacian filter: scans the interior pixels of a
// row-major image, fetches the N/W/C/E/S taps and streams the filtered result out.
module laplace_scan_ctrl #(
    parameter int ROWS   = 512,
    parameter int COLS   = 512,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        b,
    output logic [7:0]        d,
    output logic [7:0]        e,
    output logic [7:0]        f,
    output logic [7:0]        h,
    input  logic [8:0]        s,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ready
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    localparam logic [RW-1:0]     ROW_LAST = RW'(ROWS - 3);
    localparam logic [CW-1:0]     COL_LAST = CW'(COLS - 3);
    localparam logic [ADDR_W-1:0] OFS_N    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] OFS_W    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] OFS_C    = ADDR_W'(COLS + 1);
    localparam logic [ADDR_W-1:0] OFS_E    = ADDR_W'(COLS + 2);
    localparam logic [ADDR_W-1:0] OFS_S    = ADDR_W'(2 * COLS + 1);

    typedef enum logic [3:0] {IDLE, F0, F1, F2, F3, F4, LAST, WR, DONE} state_t;

    state_t            state, state_n;
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic [ADDR_W-1:0] base;    // row*COLS + col, tracked incrementally to avoid a multiplier
    logic              last_pix;
    logic              unused_s8;

    assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);
    assign wr_data   = wr_en ? s[7:0] : 8'd0;
    assign unused_s8 = s[8];

    // NOTE: every output of this block gets a default before the case so no path leaves a latch.
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        case (state)
            IDLE: if (start) state_n = F0;
            F0:   begin busy = 1'b1; rd_en = 1'b1; rd_addr = base + OFS_N; state_n = F1; end
            F1:   begin busy = 1'b1; rd_en = 1'b1; rd_addr = base + OFS_W; state_n = F2; end
            F2:   begin busy = 1'b1; rd_en = 1'b1; rd_addr = base + OFS_C; state_n = F3; end
            F3:   begin busy = 1'b1; rd_en = 1'b1; rd_addr = base + OFS_E; state_n = F4; end
            F4:   begin busy = 1'b1; rd_en = 1'b1; rd_addr = base + OFS_S; state_n = LAST; end
            LAST: begin busy = 1'b1; state_n = WR; end
            WR: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (wr_ready) state_n = last_pix ? DONE : F0;
            end
            DONE:    begin done = 1'b1; state_n = IDLE; end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            row     <= '0;
            col     <= '0;
            base    <= '0;
            wr_addr <= '0;
            b       <= '0;
            d       <= '0;
            e       <= '0;
            f       <= '0;
            h       <= '0;
        end else begin
            state <= state_n;
            case (state)
                // Each tap arrives one cycle after its read was issued.
                F1:   b <= rd_data;
                F2:   d <= rd_data;
                F3:   e <= rd_data;
                F4:   f <= rd_data;
                LAST: h <= rd_data;
                WR: begin
                    if (wr_ready && !last_pix) begin
                        wr_addr <= wr_addr + ADDR_W'(1);
                        if (col == COL_LAST) begin
                            col  <= '0;
                            row  <= row + RW'(1);
                            base <= base + ADDR_W'(3);
                        end else begin
                            col  <= col + CW'(1);
                            base <= base + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    row     <= '0;
                    col     <= '0;
                    base    <= '0;
                    wr_addr <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_laplace_scan_ctrl.sv
// Bench for laplace_scan_ctrl: a 4x4 instance for directed timing scenarios and a
// 9x13 instance for a randomized frame with random backpressure, both against a pixel model.
module tb_laplace_scan_ctrl;

    localparam int SR = 4, SC = 4, SA = 4;
    localparam int MR = 9, MC = 13, MA = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Combinational model of the external filter.
    function automatic logic [8:0] filt(input logic [7:0] n, w, c, ea, so);
        int v;
        v = 4 * int'(c) - int'(n) - int'(w) - int'(ea) - int'(so);
        return v[8:0];
    endfunction

    // ---------------- small instance ----------------
    logic          sm_rst, sm_start, sm_busy, sm_done, sm_rd_en, sm_wr_en, sm_wr_ready;
    logic [SA-1:0] sm_rd_addr, sm_wr_addr;
    logic [7:0]    sm_rd_data, sm_b, sm_d, sm_e, sm_f, sm_h, sm_wr_data;
    logic [8:0]    sm_s;
    logic [7:0]    sm_mem [SR*SC];

    always @(posedge clk) if (sm_rd_en) sm_rd_data <= sm_mem[sm_rd_addr];
    assign sm_s = filt(sm_b, sm_d, sm_e, sm_f, sm_h);

    laplace_scan_ctrl #(.ROWS(SR), .COLS(SC), .ADDR_W(SA)) u_small (
        .clk(clk), .rst(sm_rst), .start(sm_start), .busy(sm_busy), .done(sm_done),
        .rd_en(sm_rd_en), .rd_addr(sm_rd_addr), .rd_data(sm_rd_data),
        .b(sm_b), .d(sm_d), .e(sm_e), .f(sm_f), .h(sm_h), .s(sm_s),
        .wr_en(sm_wr_en), .wr_addr(sm_wr_addr), .wr_data(sm_wr_data), .wr_ready(sm_wr_ready)
    );

    // ---------------- mid instance ----------------
    logic          md_rst, md_start, md_busy, md_done, md_rd_en, md_wr_en, md_wr_ready;
    logic [MA-1:0] md_rd_addr, md_wr_addr;
    logic [7:0]    md_rd_data, md_b, md_d, md_e, md_f, md_h, md_wr_data;
    logic [8:0]    md_s;
    logic [7:0]    md_mem [MR*MC];

    always @(posedge clk) if (md_rd_en) md_rd_data <= md_mem[md_rd_addr];
    assign md_s = filt(md_b, md_d, md_e, md_f, md_h);

    laplace_scan_ctrl #(.ROWS(MR), .COLS(MC), .ADDR_W(MA)) u_mid (
        .clk(clk), .rst(md_rst), .start(md_start), .busy(md_busy), .done(md_done),
        .rd_en(md_rd_en), .rd_addr(md_rd_addr), .rd_data(md_rd_data),
        .b(md_b), .d(md_d), .e(md_e), .f(md_f), .h(md_h), .s(md_s),
        .wr_en(md_wr_en), .wr_addr(md_wr_addr), .wr_data(md_wr_data), .wr_ready(md_wr_ready)
    );

    // ---------------- reference model ----------------
    // Output pixel k sits at interior position (r+1, c+1); taps are its N, W, C, E, S neighbours.
    function automatic int tap_addr(input int cols, input int k, input int t);
        int r, c;
        r = k / (cols - 2);
        c = k % (cols - 2);
        case (t)
            0:       return r * cols + (c + 1);
            1:       return (r + 1) * cols + c;
            2:       return (r + 1) * cols + (c + 1);
            3:       return (r + 1) * cols + (c + 2);
            default: return (r + 2) * cols + (c + 1);
        endcase
    endfunction

    function automatic logic [7:0] pix(input bit mid, input int a);
        if (mid) return md_mem[a];
        return sm_mem[a];
    endfunction

    function automatic logic [7:0] ref_out(input bit mid, input int cols, input int k);
        logic [8:0] v;
        v = filt(pix(mid, tap_addr(cols, k, 0)), pix(mid, tap_addr(cols, k, 1)),
                 pix(mid, tap_addr(cols, k, 2)), pix(mid, tap_addr(cols, k, 3)),
                 pix(mid, tap_addr(cols, k, 4)));
        return v[7:0];
    endfunction

    // ---------------- small-instance trace capture ----------------
    typedef struct {
        logic          rd_en;
        logic [SA-1:0] rd_addr;
        logic          wr_en;
        logic [SA-1:0] wr_addr;
        logic [7:0]    wr_data;
        logic          acc;
        logic          busy;
        logic          done;
        logic [39:0]   taps;
    } obs_t;

    obs_t tr[$];

    // Pulses start (or holds it), then records ncyc cycles starting at the first F0.
    task automatic drive_small(input int stall_addr, input int stall_len, input bit hold_start,
                               input int ncyc);
        int   stalled;
        obs_t o;
        stalled = 0;
        tr.delete();
        @(negedge clk);
        sm_start = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            sm_wr_ready = !(sm_wr_en && int'(sm_wr_addr) == stall_addr && stalled < stall_len);
            if (!sm_wr_ready) stalled++;
            o.rd_en   = sm_rd_en;
            o.rd_addr = sm_rd_addr;
            o.wr_en   = sm_wr_en;
            o.wr_addr = sm_wr_addr;
            o.wr_data = sm_wr_data;
            o.acc     = sm_wr_en && sm_wr_ready;
            o.busy    = sm_busy;
            o.done    = sm_done;
            o.taps    = {sm_b, sm_d, sm_e, sm_f, sm_h};
            tr.push_back(o);
            sm_start = hold_start;
        end
        sm_start    = 1'b0;
        sm_wr_ready = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({sm_busy, sm_done, sm_rd_en, sm_wr_en, sm_rd_addr, sm_wr_addr, sm_b, sm_d, sm_e,
             sm_f, sm_h, sm_wr_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_small: outputs not all zero, busy=%b rd_en=%b wr_en=%b rd_addr=%0d",
                     sm_busy, sm_rd_en, sm_wr_en, sm_rd_addr);
        end
        vectors++;
        if ({md_busy, md_done, md_rd_en, md_wr_en, md_rd_addr, md_wr_addr, md_b, md_d, md_e,
             md_f, md_h, md_wr_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: outputs not all zero, busy=%b rd_en=%b wr_en=%b rd_addr=%0d",
                     md_busy, md_rd_en, md_wr_en, md_rd_addr);
        end
        sm_rst = 1'b0;
        md_rst = 1'b0;
    endtask

    task automatic test_small_frame();
        int rq[$];
        int nwr, ndone, di, bad;
        foreach (sm_mem[a]) sm_mem[a] = 8'(a);
        drive_small(-1, 0, 1'b0, 40);
        nwr = 0; ndone = 0; di = -1; bad = 0;
        foreach (tr[i]) begin
            if (tr[i].rd_en) rq.push_back(int'(tr[i].rd_addr));
            if (tr[i].done) begin ndone++; di = i; end
            if (tr[i].acc) begin
                if (int'(tr[i].wr_addr) !== nwr || tr[i].wr_data !== ref_out(0, SC, nwr)) bad++;
                nwr++;
            end
        end
        vectors++;
        if (tr[0].busy !== 1'b1 || tr[0].rd_en !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_f0: busy=%b rd_en=%b, required 1 1", tr[0].busy, tr[0].rd_en);
        end
        vectors++;
        if (rq.size() != 20) begin
            miscompares++;
            $display("FAIL frame_reads: %0d reads, required 20", rq.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                vectors++;
                if (rq[i] != tap_addr(SC, i / 5, i % 5)) begin
                    miscompares++;
                    $display("FAIL frame_rd_addr[%0d]: got %0d required %0d", i, rq[i],
                             tap_addr(SC, i / 5, i % 5));
                end
            end
        end
        vectors++;
        if (tr[6].wr_en !== 1'b1 || tr[6].taps !== {8'd1, 8'd4, 8'd5, 8'd6, 8'd9}) begin
            miscompares++;
            $display("FAIL frame_taps: wr_en=%b taps=%h required 1 0104050609", tr[6].wr_en,
                     tr[6].taps);
        end
        vectors++;
        if (nwr != 4 || bad != 0) begin
            miscompares++;
            $display("FAIL frame_writes: %0d writes, %0d bad, required 4 writes 0 bad", nwr, bad);
        end
        vectors++;
        if (ndone != 1 || di != 28 || tr[28].busy !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_done: %0d pulses, at cycle %0d, required 1 at 28 with busy low",
                     ndone, di);
        end
    endtask

    task automatic test_backpressure();
        int nwr, bad, nstall, ia, di, overlap;
        logic [7:0] held;
        foreach (sm_mem[a]) sm_mem[a] = 8'($urandom);
        drive_small(1, 3, 1'b0, 40);
        nwr = 0; bad = 0; nstall = 0; ia = -1; di = -1; overlap = 0;
        held = ref_out(0, SC, 1);
        foreach (tr[i]) begin
            if (tr[i].rd_en && tr[i].wr_en) overlap++;
            if (tr[i].done) di = i;
            if (tr[i].wr_en && !tr[i].acc) begin
                nstall++;
                if (tr[i].wr_addr !== 4'd1 || tr[i].wr_data !== held) bad++;
            end
            if (tr[i].acc) begin
                if (int'(tr[i].wr_addr) !== nwr || tr[i].wr_data !== ref_out(0, SC, nwr)) bad++;
                if (nwr == 1) ia = i;
                nwr++;
            end
        end
        vectors++;
        if (nstall != 3 || ia != 16) begin
            miscompares++;
            $display("FAIL bp_hold: %0d stalled cycles, accept at %0d, required 3 at 16", nstall, ia);
        end
        vectors++;
        if (bad != 0 || nwr != 4 || overlap != 0) begin
            miscompares++;
            $display("FAIL bp_data: bad=%0d writes=%0d read_during_write=%0d, required 0 4 0",
                     bad, nwr, overlap);
        end
        vectors++;
        if (ia < 0 || tr[ia+1].rd_en !== 1'b1 || int'(tr[ia+1].rd_addr) != tap_addr(SC, 2, 0)) begin
            miscompares++;
            $display("FAIL bp_resume: next cycle rd_addr=%0d, required %0d with rd_en",
                     (ia < 0) ? -1 : int'(tr[ia+1].rd_addr), tap_addr(SC, 2, 0));
        end
        vectors++;
        if (di != 31) begin
            miscompares++;
            $display("FAIL bp_done: done at cycle %0d, required 31", di);
        end
    endtask

    task automatic test_truncation();
        int ia;
        foreach (sm_mem[a]) sm_mem[a] = 8'd0;
        sm_mem[5] = 8'd125;  // 4*125 - 1 = 499 = 9'h1F3 for pixel 0
        sm_mem[1] = 8'd1;
        drive_small(-1, 0, 1'b0, 32);
        ia = -1;
        foreach (tr[i]) if (tr[i].acc && ia < 0) ia = i;
        vectors++;
        if (ia < 0 || tr[ia].wr_data !== 8'hF3) begin
            miscompares++;
            $display("FAIL trunc_f3: wr_data=%h required f3", (ia < 0) ? 8'hxx : tr[ia].wr_data);
        end
        vectors++;
        if (ia < 0 || tr[ia+7].wr_data !== ref_out(0, SC, 1)) begin
            miscompares++;
            $display("FAIL trunc_neg: wr_data=%h required %h", (ia < 0) ? 8'hxx : tr[ia+7].wr_data,
                     ref_out(0, SC, 1));
        end
    endtask

    task automatic test_start_spam();
        int nwr, ndone, i2;
        foreach (sm_mem[a]) sm_mem[a] = 8'($urandom);
        drive_small(-1, 0, 1'b1, 45);
        nwr = 0; ndone = 0; i2 = -1;
        for (int i = 0; i < 30; i++) begin
            if (tr[i].acc) nwr++;
            if (tr[i].done) ndone++;
        end
        for (int i = 44; i >= 30; i--) if (tr[i].acc) i2 = i;
        vectors++;
        if (nwr != 4 || ndone != 1) begin
            miscompares++;
            $display("FAIL spam_count: %0d writes %0d done, required 4 and 1", nwr, ndone);
        end
        vectors++;
        if (tr[30].rd_en !== 1'b1 || tr[30].rd_addr !== 4'd1 || tr[30].busy !== 1'b1) begin
            miscompares++;
            $display("FAIL spam_restart: rd_en=%b rd_addr=%0d, required 1 and 1", tr[30].rd_en,
                     tr[30].rd_addr);
        end
        vectors++;
        if (i2 != 36 || tr[36].wr_addr !== 4'd0 || tr[36].wr_data !== ref_out(0, SC, 0)) begin
            miscompares++;
            $display("FAIL spam_second_write: at %0d wr_addr=%0d, required cycle 36 addr 0", i2,
                     tr[36].wr_addr);
        end
    endtask

    task automatic test_reset_mid();
        int act;
        vectors++;
        if (sm_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_pre: busy=%b required 1", sm_busy);
        end
        sm_rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({sm_busy, sm_done, sm_rd_en, sm_wr_en, sm_rd_addr, sm_wr_addr, sm_b, sm_d, sm_e,
             sm_f, sm_h, sm_wr_data} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_zero: busy=%b rd_en=%b wr_en=%b taps=%h, required all 0",
                     sm_busy, sm_rd_en, sm_wr_en, {sm_b, sm_d, sm_e, sm_f, sm_h});
        end
        sm_rst = 1'b0;
        act = 0;
        repeat (30) begin
            @(negedge clk);
            if (sm_busy || sm_rd_en || sm_wr_en || sm_done) act++;
        end
        vectors++;
        if (act != 0) begin
            miscompares++;
            $display("FAIL rst_mid_quiet: %0d active cycles after abort, required 0", act);
        end
        drive_small(-1, 0, 1'b0, 10);
        vectors++;
        if (tr[0].rd_en !== 1'b1 || tr[0].rd_addr !== 4'd1) begin
            miscompares++;
            $display("FAIL rst_mid_restart: rd_en=%b rd_addr=%0d, required 1 and 1", tr[0].rd_en,
                     tr[0].rd_addr);
        end
        repeat (30) @(negedge clk);
    endtask

    task automatic test_mid_random();
        int rq[$];
        int nwr, ndone, overlap, last_wa, cyc, post, bad;
        bit seen;
        nwr = 0; ndone = 0; overlap = 0; last_wa = -1; cyc = 0; post = 0; bad = 0; seen = 0;
        foreach (md_mem[a]) md_mem[a] = 8'($urandom);
        @(negedge clk);
        md_start = 1'b1;
        while (post < 10 && cyc < 4000) begin
            @(negedge clk);
            md_start = 1'b0;
            cyc++;
            md_wr_ready = ($urandom_range(0, 3) != 0);
            if (md_rd_en) rq.push_back(int'(md_rd_addr));
            if (md_rd_en && md_wr_en) overlap++;
            if (md_wr_en && md_wr_ready) begin
                vectors++;
                if (int'(md_wr_addr) !== nwr || md_wr_data !== ref_out(1, MC, nwr)) begin
                    miscompares++;
                    $display("FAIL mid_write[%0d]: addr=%0d data=%h, required addr=%0d data=%h",
                             nwr, md_wr_addr, md_wr_data, nwr, ref_out(1, MC, nwr));
                end
                last_wa = int'(md_wr_addr);
                nwr++;
            end
            if (md_done) begin ndone++; seen = 1'b1; end
            if (seen) post++;
        end
        md_wr_ready = 1'b1;
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL mid_timeout: no done within %0d cycles", cyc);
        end
        vectors++;
        if (nwr != (MR - 2) * (MC - 2) || last_wa != (MR - 2) * (MC - 2) - 1 || ndone != 1) begin
            miscompares++;
            $display("FAIL mid_count: writes=%0d last_addr=%0d done=%0d, required %0d %0d 1",
                     nwr, last_wa, ndone, (MR - 2) * (MC - 2), (MR - 2) * (MC - 2) - 1);
        end
        foreach (rq[i]) if (rq[i] != tap_addr(MC, i / 5, i % 5)) bad++;
        vectors++;
        if (rq.size() != 5 * (MR - 2) * (MC - 2) || bad != 0 || overlap != 0) begin
            miscompares++;
            $display("FAIL mid_reads: %0d reads, %0d bad, %0d during write, required %0d 0 0",
                     rq.size(), bad, overlap, 5 * (MR - 2) * (MC - 2));
        end
        vectors++;
        if (rq.size() == 0 || rq[rq.size()-1] != (MR - 1) * MC + MC - 2) begin
            miscompares++;
            $display("FAIL mid_last_read: got %0d required %0d",
                     (rq.size() == 0) ? -1 : rq[rq.size()-1], (MR - 1) * MC + MC - 2);
        end
    endtask

    initial begin
        sm_rst = 1'b1; sm_start = 1'b0; sm_wr_ready = 1'b1;
        md_rst = 1'b1; md_start = 1'b0; md_wr_ready = 1'b1;
        foreach (sm_mem[a]) sm_mem[a] = 8'd0;
        foreach (md_mem[a]) md_mem[a] = 8'd0;
        test_reset();
        test_small_frame();
        test_backpressure();
        test_truncation();
        test_start_spam();
        test_reset_mid();
        test_mid_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
